// File: rtl/dram_loader_pkg.sv
// Shared definitions for the DRAM diagnostic loader: sub-function codes,
// DRAM word layout, FSM state encoding and the DRAM parity rule.
package dram_loader_pkg;

  localparam logic [2:0] DIAG_DRAM_XY_EVEN = 3'd0;
  localparam logic [2:0] DIAG_DRAM_XY_ODD  = 3'd1;
  localparam logic [2:0] DIAG_DRAM_J_COMM  = 3'd2;
  localparam logic [2:0] DIAG_DRAM_J_EVEN  = 3'd3;
  localparam logic [2:0] DIAG_DRAM_J_ODD   = 3'd4;

  localparam int DRAM_A_HI    = 23;
  localparam int DRAM_A_LO    = 21;
  localparam int DRAM_B_HI    = 20;
  localparam int DRAM_B_LO    = 18;
  localparam int DRAM_PAR_BIT = 17;
  localparam int DRAM_JC_HI   = 16;
  localparam int DRAM_JC_LO   = 13;
  localparam int DRAM_JX_HI   = 12;
  localparam int DRAM_JX_LO   = 9;

  // Bits [23:9] are covered by parity; [8:0] are always zero.
  localparam logic [23:0] DRAM_PARITY_MASK = 24'hFFFE00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_EVEN,
    ST_WR_ODD,
    ST_RD_EVEN,
    ST_RD_ODD,
    ST_CMP_ODD
  } state_t;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic       par;
  } xy_t;

  // A DRAM word is good when its covered bits hold an odd number of ones.
  function automatic logic dramOddParity(input logic [23:0] word);
    return ^(word & DRAM_PARITY_MASK);
  endfunction

endpackage

// File: rtl/dram_word_pack.sv
// Packs the A/B/PAR and J fields into one 24-bit DRAM word and reports
// whether the result has good (odd) parity.
module dram_word_pack
  import dram_loader_pkg::*;
(
  input  xy_t         xy,
  input  logic [3:0]  j_common,
  input  logic [3:0]  j_side,
  output logic [23:0] word,
  output logic        parity_good
);

  always_comb begin
    word                           = '0;
    word[DRAM_A_HI:DRAM_A_LO]      = xy.a;
    word[DRAM_B_HI:DRAM_B_LO]      = xy.b;
    word[DRAM_PAR_BIT]             = xy.par;
    word[DRAM_JC_HI:DRAM_JC_LO]    = j_common;
    word[DRAM_JX_HI:DRAM_JX_LO]    = j_side;
  end

  assign parity_good = dramOddParity(word);

endmodule

// File: rtl/dram_loader.sv
// Collects the five DRAM diagnostic load fields from the EBUS, then writes,
// reads back and verifies one even/odd DRAM entry pair.
module dram_loader
  import dram_loader_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic        diagStrobe,
  input  logic [0:2]  diagFunc,
  input  logic [0:35] EBUS,
  input  logic [0:7]  pairAddr,
  input  logic        clearStatus,
  input  logic [23:0] dramDout,
  output logic        dramEn,
  output logic        dramWe,
  output logic [0:8]  dramAddr,
  output logic [23:0] dramDin,
  output logic [0:4]  fieldMask,
  output logic        busy,
  output logic        done,
  output logic        parityErr,
  output logic        verifyErr,
  output logic        overrun
);

  state_t      state_q, state_d;
  xy_t         xy_even_q, xy_even_d, xy_odd_q, xy_odd_d;
  logic [3:0]  j_common_q, j_common_d, j_even_q, j_even_d, j_odd_q, j_odd_d;
  logic [0:4]  mask_q, mask_d;
  logic [0:7]  pair_q;
  logic [23:0] even_word_q, odd_word_q, even_word_d, odd_word_d;
  logic        even_good, odd_good;
  logic        func_valid, capture, start, odd_sel, verify_fail;
  logic        parity_err_q, verify_err_q, overrun_q;
  logic        unused_ebus;

  assign unused_ebus = ^EBUS[7:35];
  assign func_valid  = (diagFunc <= DIAG_DRAM_J_ODD);
  assign capture     = diagStrobe && func_valid && (state_q == ST_IDLE);
  assign start       = capture && (&mask_d);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    xy_even_d  = xy_even_q;
    xy_odd_d   = xy_odd_q;
    j_common_d = j_common_q;
    j_even_d   = j_even_q;
    j_odd_d    = j_odd_q;
    mask_d     = mask_q;
    if (capture) begin
      case (diagFunc)
        DIAG_DRAM_XY_EVEN: begin xy_even_d  = xy_t'(EBUS[0:6]); mask_d[0] = 1'b1; end
        DIAG_DRAM_XY_ODD:  begin xy_odd_d   = xy_t'(EBUS[0:6]); mask_d[1] = 1'b1; end
        DIAG_DRAM_J_COMM:  begin j_common_d = EBUS[0:3];        mask_d[2] = 1'b1; end
        DIAG_DRAM_J_EVEN:  begin j_even_d   = EBUS[0:3];        mask_d[3] = 1'b1; end
        DIAG_DRAM_J_ODD:   begin j_odd_d    = EBUS[0:3];        mask_d[4] = 1'b1; end
        default: ;
      endcase
    end
    if (state_q == ST_CMP_ODD) mask_d = '0;
  end

  // Pack from the post-capture field values so the words latched at start
  // already include the field delivered by the final strobe.
  dram_word_pack u_pack_even (
    .xy(xy_even_d), .j_common(j_common_d), .j_side(j_even_d),
    .word(even_word_d), .parity_good(even_good)
  );

  dram_word_pack u_pack_odd (
    .xy(xy_odd_d), .j_common(j_common_d), .j_side(j_odd_d),
    .word(odd_word_d), .parity_good(odd_good)
  );

  always_comb begin
    state_d     = state_q;
    busy        = 1'b1;
    done        = 1'b0;
    dramEn      = 1'b0;
    dramWe      = 1'b0;
    odd_sel     = 1'b0;
    verify_fail = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_WR_EVEN;
      end
      ST_WR_EVEN: begin dramEn = 1'b1; dramWe = 1'b1; state_d = ST_WR_ODD; end
      ST_WR_ODD:  begin dramEn = 1'b1; dramWe = 1'b1; odd_sel = 1'b1; state_d = ST_RD_EVEN; end
      ST_RD_EVEN: begin dramEn = 1'b1; state_d = ST_RD_ODD; end
      ST_RD_ODD: begin
        dramEn      = 1'b1;
        odd_sel     = 1'b1;
        verify_fail = (dramDout != even_word_q);
        state_d     = ST_CMP_ODD;
      end
      ST_CMP_ODD: begin
        done        = 1'b1;
        verify_fail = (dramDout != odd_word_q);
        state_d     = ST_IDLE;
      end
      default: begin busy = 1'b0; state_d = ST_IDLE; end
    endcase
  end

  // The DRAM port is driven only from state and latched words, never from EBUS.
  assign dramAddr  = {pair_q, odd_sel};
  assign dramDin   = odd_sel ? odd_word_q : even_word_q;
  assign fieldMask = mask_q;
  assign parityErr = parity_err_q;
  assign verifyErr = verify_err_q;
  assign overrun   = overrun_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      xy_even_q    <= '0;
      xy_odd_q     <= '0;
      j_common_q   <= '0;
      j_even_q     <= '0;
      j_odd_q      <= '0;
      mask_q       <= '0;
      pair_q       <= '0;
      even_word_q  <= '0;
      odd_word_q   <= '0;
      parity_err_q <= 1'b0;
      verify_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      xy_even_q  <= xy_even_d;
      xy_odd_q   <= xy_odd_d;
      j_common_q <= j_common_d;
      j_even_q   <= j_even_d;
      j_odd_q    <= j_odd_d;
      mask_q     <= mask_d;
      if (start) begin
        pair_q      <= pairAddr;
        even_word_q <= even_word_d;
        odd_word_q  <= odd_word_d;
      end
      // A flag raised in the same cycle as clearStatus survives the clear.
      parity_err_q <= (parity_err_q & ~clearStatus) | (start & ~(even_good & odd_good));
      verify_err_q <= (verify_err_q & ~clearStatus) | verify_fail;
      overrun_q    <= (overrun_q & ~clearStatus) | (diagStrobe & func_valid & busy);
    end
  end

endmodule

// File: tb/tb_dram_loader.sv
// Randomised self-checking bench for dram_loader with a behavioural DRAM
// and a field-level reference model of the load/write/verify sequence.
module tb_dram_loader;

  logic        clk = 1'b0;
  logic        resetN, diagStrobe, clearStatus;
  logic [0:2]  diagFunc;
  logic [0:35] EBUS;
  logic [0:7]  pairAddr;
  logic [23:0] dramDout;
  logic        dramEn, dramWe;
  logic [0:8]  dramAddr;
  logic [23:0] dramDin;
  logic [0:4]  fieldMask;
  logic        busy, done, parityErr, verifyErr, overrun;

  int total = 0;
  int bad   = 0;

  logic [23:0] mem [0:511];
  logic        corrupt_odd;

  // Reference model state
  logic [6:0] m_xy [2];
  logic [3:0] m_jc, m_je, m_jo;
  logic [0:4] m_mask;
  logic       m_par, m_ver, m_ovr;

  always #5 clk = ~clk;

  dram_loader dut (
    .clk(clk), .resetN(resetN), .diagStrobe(diagStrobe), .diagFunc(diagFunc),
    .EBUS(EBUS), .pairAddr(pairAddr), .clearStatus(clearStatus), .dramDout(dramDout),
    .dramEn(dramEn), .dramWe(dramWe), .dramAddr(dramAddr), .dramDin(dramDin),
    .fieldMask(fieldMask), .busy(busy), .done(done), .parityErr(parityErr),
    .verifyErr(verifyErr), .overrun(overrun)
  );

  // DRAM with one-cycle read latency; optional single-bit fault on odd reads.
  always @(posedge clk) begin
    if (dramEn) begin
      if (dramWe) mem[dramAddr] <= dramDin;
      else dramDout <= mem[dramAddr] ^ ((corrupt_odd && dramAddr[8]) ? 24'h000400 : 24'h0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ref_word(input logic [6:0] xy, input logic [3:0] jc,
                                           input logic [3:0] jx);
    return {xy, jc, jx, 9'd0};
  endfunction

  function automatic bit ref_good(input logic [23:0] w);
    return ($countones(w[23:9]) % 2) == 1;
  endfunction

  function automatic logic [35:0] mk_xy(input logic [6:0] xy);
    return {xy, 29'($urandom)};
  endfunction

  function automatic logic [35:0] mk_j(input logic [3:0] j);
    return {j, 32'($urandom)};
  endfunction

  // One strobe in IDLE; returns at the falling edge after the sampling edge.
  task automatic strobe(input logic [2:0] code, input logic [35:0] data);
    @(negedge clk);
    diagStrobe = 1'b1;
    diagFunc   = code;
    EBUS       = data;
    @(negedge clk);
    diagStrobe = 1'b0;
    diagFunc   = 3'($urandom);
    EBUS       = 36'({$urandom, $urandom});
    if (code <= 3'd4) begin
      m_mask[code] = 1'b1;
      case (code)
        3'd0: m_xy[0] = data[35:29];
        3'd1: m_xy[1] = data[35:29];
        3'd2: m_jc    = data[35:32];
        3'd3: m_je    = data[35:32];
        default: m_jo = data[35:32];
      endcase
    end
  endtask

  task automatic clear_flags(input string tag);
    @(negedge clk);
    clearStatus = 1'b1;
    @(negedge clk);
    clearStatus = 1'b0;
    m_par = 1'b0; m_ver = 1'b0; m_ovr = 1'b0;
    check(tag, {parityErr, verifyErr, overrun}, {m_par, m_ver, m_ovr});
  endtask

  task automatic run_pair(input logic [6:0] xe, input logic [6:0] xo, input logic [3:0] jc,
                          input logic [3:0] je, input logic [3:0] jo, input logic [7:0] addr,
                          input bit corrupt, input bit ovr, input bit clr5);
    int          order [5];
    int          tmp, k;
    logic [23:0] ew, ow;
    logic [3:0]  exp_ctrl;
    logic        exp_odd;

    corrupt_odd = corrupt;
    for (int i = 0; i < 5; i++) order[i] = i;
    for (int i = 4; i > 0; i--) begin
      k = $urandom_range(i, 0);
      tmp = order[i]; order[i] = order[k]; order[k] = tmp;
    end
    if (order[4] == 0) begin tmp = order[4]; order[4] = order[0]; order[0] = tmp; end

    // Decoy XY even (overwritten later) and an unused code.
    strobe(3'd0, mk_xy(xe ^ 7'h55));
    check("mask_decoy", fieldMask, m_mask);
    strobe(3'($urandom_range(7, 5)), 36'({$urandom, $urandom}));
    check("mask_ignored_code", fieldMask, m_mask);

    for (int i = 0; i < 5; i++) begin
      logic [2:0]  c;
      logic [35:0] d;
      c = 3'(order[i]);
      case (c)
        3'd0: d = mk_xy(xe);
        3'd1: d = mk_xy(xo);
        3'd2: d = mk_j(jc);
        3'd3: d = mk_j(je);
        default: d = mk_j(jo);
      endcase
      pairAddr = (i == 4) ? addr : 8'($urandom);
      strobe(c, d);
      if (i < 4) check("mask_load", fieldMask, m_mask);
    end
    pairAddr = 8'($urandom);

    ew = ref_word(m_xy[0], m_jc, m_je);
    ow = ref_word(m_xy[1], m_jc, m_jo);
    if (!ref_good(ew) || !ref_good(ow)) m_par = 1'b1;

    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (cyc > 1) @(negedge clk);
      exp_odd = (cyc == 2) || (cyc == 4);
      case (cyc)
        1, 2:    exp_ctrl = 4'b1011;
        3, 4:    exp_ctrl = 4'b1010;
        5:       exp_ctrl = 4'b1100;
        default: exp_ctrl = 4'b0000;
      endcase
      check($sformatf("ctrl_cyc%0d", cyc), {busy, done, dramEn, dramWe}, exp_ctrl);
      if (exp_ctrl[1]) check($sformatf("addr_cyc%0d", cyc), dramAddr, {addr, exp_odd});
      if (exp_ctrl[0]) check($sformatf("din_cyc%0d", cyc), dramDin, exp_odd ? ow : ew);
      if (cyc == 1) check("parity_t1", parityErr, m_par);
      if (cyc == 3) check("mask_busy", fieldMask, 5'b11111);
      if (ovr && cyc == 2) begin
        diagStrobe = 1'b1;
        diagFunc   = 3'd3;
        EBUS       = 36'({$urandom, $urandom});
        m_ovr      = 1'b1;
      end
      if (cyc == 3) diagStrobe = 1'b0;
      if (cyc == 5) begin
        if (clr5) begin
          clearStatus = 1'b1;
          m_par = 1'b0; m_ovr = 1'b0; m_ver = 1'b0;
        end
        if (corrupt) m_ver = 1'b1;
      end
      if (cyc == 6) begin
        clearStatus = 1'b0;
        m_mask = '0;
        check("flags_end", {parityErr, verifyErr, overrun}, {m_par, m_ver, m_ovr});
        check("mask_end", fieldMask, m_mask);
        check("mem_even", mem[{addr, 1'b0}], ew);
        check("mem_odd", mem[{addr, 1'b1}], ow);
      end
    end
    corrupt_odd = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; diagStrobe = 1'b0; clearStatus = 1'b0; diagFunc = '0;
    EBUS = '0; pairAddr = '0; corrupt_odd = 1'b0; dramDout = '0;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    m_xy[0] = '0; m_xy[1] = '0; m_jc = '0; m_je = '0; m_jo = '0;
    m_mask = '0; m_par = 1'b0; m_ver = 1'b0; m_ovr = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_outputs",
          {dramEn, dramWe, dramAddr, dramDin, fieldMask, busy, done, parityErr, verifyErr, overrun},
          45'd0);
    resetN = 1'b1;

    // Full pair with the reference field values.
    run_pair({3'd3, 3'd5, 1'b1}, {3'd1, 3'd2, 1'b0}, 4'hA, 4'h3, 4'hC, 8'h2B, 0, 0, 0);
    clear_flags("clear_after_full");

    // Bad even parity only; flag must persist until cleared.
    run_pair({3'd3, 3'd5, 1'b0}, {3'd1, 3'd2, 1'b1}, 4'hA, 4'h3, 4'hC, 8'h11, 0, 0, 0);
    repeat (4) @(negedge clk);
    check("parity_sticky", parityErr, m_par);
    clear_flags("clear_parity");

    // Odd read-back fault, then strobe while busy.
    run_pair({3'd6, 3'd1, 1'b1}, {3'd2, 3'd7, 1'b0}, 4'h5, 4'h9, 4'h2, 8'hC4, 1, 0, 0);
    run_pair({3'd0, 3'd4, 1'b1}, {3'd5, 3'd3, 1'b1}, 4'h7, 4'h1, 4'hE, 8'h3F, 0, 1, 0);
    // Clear in the compare cycle while a verify error is being raised.
    run_pair({3'd2, 3'd2, 1'b0}, {3'd6, 3'd6, 1'b1}, 4'h0, 4'hF, 4'h8, 8'h80, 1, 1, 1);
    clear_flags("clear_mid");

    // Reset during WR_ODD, then a fresh pair.
    for (int i = 0; i < 5; i++) begin
      pairAddr = 8'h5A;
      strobe(3'(i), (i < 2) ? mk_xy(7'($urandom)) : mk_j(4'($urandom)));
    end
    @(negedge clk);
    check("wr_odd_we", {dramEn, dramWe}, 2'b11);
    #2 resetN = 1'b0;
    #1 check("reset_mid_outputs",
             {dramEn, dramWe, dramAddr, dramDin, fieldMask, busy, done, parityErr, verifyErr, overrun},
             45'd0);
    m_mask = '0; m_par = 1'b0; m_ver = 1'b0; m_ovr = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    run_pair({3'd7, 3'd0, 1'b1}, {3'd4, 3'd4, 1'b0}, 4'h6, 4'hB, 4'h4, 8'hE7, 0, 0, 0);

    // Randomised pairs.
    for (int n = 0; n < 20; n++) begin
      run_pair(7'($urandom), 7'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
               8'($urandom), ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0),
               ($urandom_range(4, 0) == 0));
      if ($urandom_range(2, 0) == 0) clear_flags("clear_random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
